// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and helpers shared by the sync
// generator and the pixel renderers.
package vga_timing_pkg;

    localparam int H_DISP = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_DISP = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam int HSYNC_START = H_DISP + H_FP;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int VSYNC_START = V_DISP + V_FP;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

    localparam int SCREEN_W = H_DISP;
    localparam int SCREEN_H = V_DISP;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive range test used for the sync windows.
    function automatic logic in_span(input coord_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: divides clk by CLK_DIV, emitting a registered one-clk
// p_tick CLK_DIV clocks after reset and every CLK_DIV clocks thereafter.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be at least 1");
    end

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_q == LAST);
        end
    end

    assign p_tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel x/y, hsync/vsync, video_on, frame_start.
// Define VGA_PIXEL_DELAY_EN to delay hsync/vsync/video_on by one pixel.
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = vga_timing_pkg::H_DISP,
    parameter int H_FP    = vga_timing_pkg::H_FP,
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BP    = vga_timing_pkg::H_BP,
    parameter int V_DISP  = vga_timing_pkg::V_DISP,
    parameter int V_FP    = vga_timing_pkg::V_FP,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BP    = vga_timing_pkg::V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    import vga_timing_pkg::*;

    localparam int HT    = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_DISP + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC - 1;
    localparam int VS_LO = V_DISP + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC - 1;

    localparam coord_t X_LAST = coord_t'(HT - 1);
    localparam coord_t Y_LAST = coord_t'(VT - 1);

    if (HT > 1024 || VT > 1024) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end

    logic   tick;
    coord_t x_q, x_d, y_q, y_d;
    logic   hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic   vid_raw;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (tick)
    );

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fs_d = 1'b0;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        // Syncs decode the next-state counters so they land with their x/y.
        hs_d = !in_span(x_d, HS_LO, HS_HI);
        vs_d = !in_span(y_d, VS_LO, VS_HI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            fs_q <= fs_d;
        end
    end

    assign vid_raw = (x_q < coord_t'(H_DISP)) && (y_q < coord_t'(V_DISP));

`ifdef VGA_PIXEL_DELAY_EN
    // One pixel of lag to line up with the registered glyph ROM downstream.
    logic hs_dly_q, vs_dly_q, vo_dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
            vo_dly_q <= 1'b1;
        end else if (tick) begin
            hs_dly_q <= hs_q;
            vs_dly_q <= vs_q;
            vo_dly_q <= vid_raw;
        end
    end

    assign hsync    = hs_dly_q;
    assign vsync    = vs_dly_q;
    assign video_on = vo_dly_q;
`else
    assign hsync    = hs_q;
    assign vsync    = vs_q;
    assign video_on = vid_raw;
`endif

    assign p_tick      = tick;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: dut_a runs the default 640x480 timing for one line;
// dut_b runs a shrunken raster so full frames and mid-frame reset fit a short run.
module tb_vga_sync_gen;

    typedef struct {
        int         cyc;
        string      tag;
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fs;
    } exp_t;

    typedef struct {
        int div, hd, hf, hsy, hb, vd, vf, vsy, vb;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic       pt_a, vo_a, hs_a, vs_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       pt_b, vo_b, hs_b, vs_b, fs_b;
    logic [9:0] x_b, y_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sync_gen dut_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .x(x_a), .y(y_a),
        .video_on(vo_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .x(x_b), .y(y_b),
        .video_on(vo_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    // Expected outputs from the pixel index elapsed since the reset edge `rel`.
    function automatic exp_t model(input cfg_t g, input int rel, input int c, input string tag);
        exp_t e;
        int ht, vt, n, ph, m, mx, my;
        ht = g.hd + g.hf + g.hsy + g.hb;
        vt = g.vd + g.vf + g.vsy + g.vb;
        e.cyc = c;
        e.tag = tag;
        if (c <= rel) begin
            e.pt = 1'b0; e.x = '0; e.y = '0;
            e.hs = 1'b1; e.vs = 1'b1; e.vo = 1'b1; e.fs = 1'b0;
            return e;
        end
        n  = (c - rel - 1) / g.div;
        ph = (c - rel - 1) % g.div;
        e.x  = 10'(n % ht);
        e.y  = 10'((n / ht) % vt);
        e.pt = (ph == g.div - 1);
        e.fs = (n > 0) && (e.x == 0) && (e.y == 0) && (ph == 0);
        m = n;
`ifdef VGA_PIXEL_DELAY_EN
        m = n - 1;
`endif
        if (m < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.vo = 1'b1;
        end else begin
            mx = m % ht;
            my = (m / ht) % vt;
            e.hs = !((mx >= g.hd + g.hf) && (mx < g.hd + g.hf + g.hsy));
            e.vs = !((my >= g.vd + g.vf) && (my < g.vd + g.vf + g.vsy));
            e.vo = (mx < g.hd) && (my < g.vd);
        end
        return e;
    endfunction

    function automatic exp_t lit(input int c, input string tag, input int xv, input int yv,
                                 input logic hs, input logic vs, input logic vo, input logic fs);
        exp_t e;
        e.cyc = c; e.tag = tag; e.pt = 1'b0;
        e.x = 10'(xv); e.y = 10'(yv);
        e.hs = hs; e.vs = vs; e.vo = vo; e.fs = fs;
        return e;
    endfunction

    task automatic check(input exp_t e, input logic pt, input logic [9:0] xv, input logic [9:0] yv,
                         input logic hs, input logic vs, input logic vo, input logic fs);
        checks++;
        if (e.cyc != cyc || {pt, xv, yv, hs, vs, vo, fs} !== {e.pt, e.x, e.y, e.hs, e.vs, e.vo, e.fs}) begin
            errors++;
            $display("FAIL %s cyc=%0d(want %0d) got pt=%0d x=%0d y=%0d hs=%0d vs=%0d vo=%0d fs=%0d exp pt=%0d x=%0d y=%0d hs=%0d vs=%0d vo=%0d fs=%0d",
                     e.tag, cyc, e.cyc, pt, xv, yv, hs, vs, vo, fs,
                     e.pt, e.x, e.y, e.hs, e.vs, e.vo, e.fs);
        end
    endtask

    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].cyc <= cyc)
            check(qa.pop_front(), pt_a, x_a, y_a, hs_a, vs_a, vo_a, fs_a);
        while (qb.size() > 0 && qb[0].cyc <= cyc)
            check(qb.pop_front(), pt_b, x_b, y_b, hs_b, vs_b, vo_b, fs_b);
    end

    // Hand-computed checkpoints for the default timing (pixel n, x, y, hsync, video_on).
    int   la_n[9]  = '{0, 639, 640, 655, 656, 751, 752, 799, 800};
    int   la_x[9]  = '{0, 639, 640, 655, 656, 751, 752, 799, 0};
    int   la_y[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic la_hs[9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
    logic la_vo[9] = '{1, 1, 0, 0, 0, 0, 0, 0, 1};
    // Shrunken raster: 15x12 totals, hsync x=10..12, vsync y=8..9.
    int   lb_n[3]  = '{179, 180, 506};
    int   lb_x[3]  = '{14, 0, 11};
    int   lb_y[3]  = '{11, 0, 9};
    logic lb_hs[3] = '{1, 1, 0};
    logic lb_vs[3] = '{1, 1, 0};
    logic lb_vo[3] = '{0, 1, 0};
    logic lb_fs[3] = '{0, 1, 0};

    initial begin
        cfg_t ga, gb;
        int rel, relb, rel2, c;
        ga = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        gb = '{2, 8, 2, 3, 2, 6, 2, 2, 2};

        // dut_a: reset 5 clks, then one full line plus the wrap into line 1.
        repeat (5) @(posedge clk);
        #1;
        rel = cyc;
        rst_a = 1'b0;
        qa.push_back(model(ga, rel, rel, "a_reset"));
        for (int n = 0; n <= 801; n++) begin
            for (int ph = 0; ph < ((n < 3) ? 4 : 1); ph++) begin
                c = rel + 1 + 4 * n + ph;
                qa.push_back(model(ga, rel, c, (n < 3) ? "a_tick" : "a_pix"));
`ifndef VGA_PIXEL_DELAY_EN
                if (ph == 0)
                    for (int k = 0; k < 9; k++)
                        if (la_n[k] == n)
                            qa.push_back(lit(c, "a_lit", la_x[k], la_y[k], la_hs[k], 1'b1, la_vo[k], 1'b0));
`endif
            end
        end
        while (qa.size() > 0) @(posedge clk);

        // dut_b: two full frames, then reset while both syncs are low on a tick.
        @(posedge clk);
        #1;
        relb = cyc;
        rst_b = 1'b0;
        for (int cc = relb; cc <= relb + 1014; cc++) begin
            qb.push_back(model(gb, relb, cc, "b_pix"));
`ifndef VGA_PIXEL_DELAY_EN
            if (cc > relb && (cc - relb - 1) % 2 == 0)
                for (int k = 0; k < 3; k++)
                    if (lb_n[k] == (cc - relb - 1) / 2)
                        qb.push_back(lit(cc, "b_lit", lb_x[k], lb_y[k], lb_hs[k], lb_vs[k], lb_vo[k], lb_fs[k]));
`endif
        end
        while (cyc < relb + 1014) begin
            @(posedge clk);
            #1;
        end
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rel2 = cyc;
        rst_b = 1'b0;
        qb.push_back(model(gb, rel2, rel2, "b_midrst"));
        qb.push_back(lit(rel2, "b_midrst_lit", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int cc = rel2 + 1; cc <= rel2 + 20; cc++)
            qb.push_back(model(gb, rel2, cc, "b_after_rst"));
        while (qb.size() > 0) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator for 640x480 @ 60 Hz on the Basys 3 100 MHz clock.
- Produces the pixel coordinates x/y that the text, graphics and ball renderers consume, plus hsync/vsync for the VGA connector.
- Also produces video_on, a pixel-enable tick and a frame-start pulse.
- It is the source end of the x/y/video_on interface that every pixel-generation block reads.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz / 4 = 25 MHz).
- H_DISP, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_DISP, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- p_tick  out  1  one-clk pulse; advances the pixel position.
- x  out  10  current pixel column, 0..H_TOTAL-1.
- y  out  10  current line, 0..V_TOTAL-1.
- video_on  out  1  high while x<H_DISP and y<V_DISP.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- frame_start  out  1  one-clk pulse when x,y wrap to 0,0.

Behaviour:
- Interface (already decided): one clock, clk. Reset is port reset, synchronous and active-high. All state updates on the rising edge of clk.
- Derived totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800. V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP = 525.
- Reset values: div counter 0, x=0, y=0, p_tick=0, hsync=1, vsync=1, frame_start=0. video_on=1, since it is decoded from x=0, y=0.
- Divider: counter runs 0..CLK_DIV-1 and wraps. p_tick is registered and is 1 in the cycle after the counter reaches CLK_DIV-1. First p_tick is CLK_DIV clocks after reset deasserts; period is exactly CLK_DIV clocks.
- Horizontal counter: in a clock where p_tick=1, x increments. When x=H_TOTAL-1, x wraps to 0. x holds when p_tick=0.
- Vertical counter: y increments only when p_tick=1 and x=H_TOTAL-1. When y=V_TOTAL-1 at that point, y wraps to 0.
- hsync, vsync and frame_start are registered from the next-state counter values, so they align with the x/y values they accompany. Zero-cycle skew between x/y and the sync outputs.
- hsync=0 iff x in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1], i.e. 656..751.
- vsync=0 iff y in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1], i.e. 490..491.
- video_on is combinational from registered x/y.
- frame_start=1 for exactly one clk, the clock in which x,y become 0,0 through wrap. It does not fire on reset exit.
- Reset mid-frame: next clk x=0, y=0, hsync=1, vsync=1, divider=0. No partial sync pulse is emitted.
- Reset has priority over every count event in the same cycle.
- Width rule: counters are 10-bit unsigned. Parameter combinations with H_TOTAL or V_TOTAL >1024 are illegal; an elaboration check flags them.

Optional Feature:
- Macro: VGA_PIXEL_DELAY_EN.
- When defined: hsync, vsync and video_on each pass through one extra register stage, enabled by p_tick. This compensates the 1-cycle registered ascii/bitmap ROM latency in downstream text renderers. x/y are not delayed. Reset values of the delay stages are 1, 1, 1.
- When undefined: outputs are exactly as in Behaviour, with no added delay.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (H_DISP…V_BP);
  - the derived H_TOTAL and V_TOTAL;
  - HSYNC_START/END and VSYNC_START/END localparams;
  - the screen-size constants used by the renderers.
- One sub-module, pixel_tick_gen: parameter CLK_DIV; ports clk, reset, p_tick. It contains the divider only.

Test Plan:
- Reset held 5 clks, then released. Expect x=0, y=0, hsync=1, vsync=1, video_on=1. First p_tick at clk 4 after release, then every 4 clks.
- Run 1 line. x sequences 0..799 then 0, with y incrementing 0→1 at the wrap. hsync low for exactly 96 p_ticks, starting at x=656. video_on falls at x=640.
- Run 1 full frame. vsync low for exactly 2 lines (1600 p_ticks), starting at y=490, x=0. frame_start pulses once. Pulse spacing is 420000 p_ticks = 1,680,000 clks.
- Assert reset at x=700, y=491, while both syncs are low. Next clk expect x=0, y=0, hsync=1, vsync=1, and no frame_start.
- Boundary: at x=799, y=524, with p_tick. Next state x=0, y=0, frame_start=1 for one clk, video_on=1.
- With VGA_PIXEL_DELAY_EN defined: hsync falls one p_tick after x reaches 656. video_on falls one p_tick after x reaches 640.
